// File: rtl/load_store_unit.sv
// Load/store unit between the ALU and a word-organised data memory. It handles
// byte/halfword/word loads with extension, and does sub-word stores as read-modify-write.
module load_store_unit #(
  parameter int WORD_ADDR_BITS = 5
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Start,
  input  logic [2:0]  MemOp,
  input  logic [31:0] Address,
  input  logic [31:0] Store_Data,
  input  logic [31:0] Mem_Read_Data,
  output logic [31:0] Mem_Adress,
  output logic [31:0] Mem_Write_Data,
  output logic        Mem_Write,
  output logic        Mem_Read,
  output logic [31:0] Load_Data,
  output logic        Busy,
  output logic        Done,
  output logic        Misaligned,
  output logic        Out_Of_Range
);

  localparam int AW = WORD_ADDR_BITS + 2;

  localparam logic [2:0] OP_LB  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LW  = 3'b010;
  localparam logic [2:0] OP_LBU = 3'b011;
  localparam logic [2:0] OP_LHU = 3'b100;
  localparam logic [2:0] OP_SB  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SW  = 3'b111;

  // Bit 0 is the read strobe and bit 1 the write strobe, so both come straight off a flop.
  typedef enum logic [2:0] {
    S_IDLE = 3'b000,
    S_RD   = 3'b001,
    S_WR   = 3'b010,
    S_DONE = 3'b100
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [2:0]      r_op;
  logic [AW-1:0]   r_addr;
  logic [31:0]     r_wdata;
  logic [15:0]     r_sdata_lo;
  logic [31:0]     r_load;
  logic            r_mis;
  logic            r_oor;
  logic            w_accept;
  logic            w_mis;
  logic            w_oor;
  logic            w_rmw;
  logic [31:0]     w_word_idx;

  function automatic logic f_is_store(input logic [2:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic logic f_misaligned(input logic [2:0] op, input logic [1:0] lane);
    logic mis;
    mis = 1'b0;
    case (op)
      OP_LH, OP_LHU, OP_SH: mis = lane[0];
      OP_LW, OP_SW:         mis = |lane;
      default:              mis = 1'b0;
    endcase
    return mis;
  endfunction

  function automatic logic f_out_of_range(input logic [31:0] addr);
    return (addr >> AW) != 32'd0;
  endfunction

  function automatic logic [31:0] f_load_extend(input logic [2:0]  op,
                                                input logic [1:0]  lane,
                                                input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] res;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];
    case (op)
      OP_LB:   res = {{24{b[7]}}, b};
      OP_LH:   res = {{16{h[15]}}, h};
      OP_LBU:  res = {24'd0, b};
      OP_LHU:  res = {16'd0, h};
      default: res = word;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] f_store_merge(input logic [2:0]  op,
                                                input logic [1:0]  lane,
                                                input logic [31:0] word,
                                                input logic [15:0] sdata);
    logic [31:0] res;
    res = word;
    if (op == OP_SB) begin
      case (lane)
        2'd0:    res[7:0]   = sdata[7:0];
        2'd1:    res[15:8]  = sdata[7:0];
        2'd2:    res[23:16] = sdata[7:0];
        default: res[31:24] = sdata[7:0];
      endcase
    end else if (lane[1]) begin
      res[31:16] = sdata;
    end else begin
      res[15:0] = sdata;
    end
    return res;
  endfunction

  assign w_accept = (r_state == S_IDLE) && Start;
  assign w_mis    = f_misaligned(MemOp, Address[1:0]);
  assign w_oor    = f_out_of_range(Address);
  assign w_rmw    = (r_op == OP_SB) || (r_op == OP_SH);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (Start) begin
          if (w_mis || w_oor)       w_next = S_DONE;
          else if (MemOp == OP_SW)  w_next = S_WR;
          else                      w_next = S_RD;
        end
      end
      S_RD:    w_next = w_rmw ? S_WR : S_DONE;
      S_WR:    w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= S_IDLE;
      r_load  <= 32'd0;
      r_mis   <= 1'b0;
      r_oor   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_mis <= w_mis;
        r_oor <= w_oor;
      end
      if ((r_state == S_RD) && !f_is_store(r_op))
        r_load <= f_load_extend(r_op, r_addr[1:0], Mem_Read_Data);
    end
  end

  // Operand capture; the outputs that expose these are gated by state, so no reset needed.
  always_ff @(posedge Clk) begin
    if (w_accept) begin
      r_op       <= MemOp;
      r_addr     <= Address[AW-1:0];
      r_wdata    <= Store_Data;
      r_sdata_lo <= Store_Data[15:0];
    end else if ((r_state == S_RD) && w_rmw) begin
      r_wdata <= f_store_merge(r_op, r_addr[1:0], Mem_Read_Data, r_sdata_lo);
    end
  end

  assign w_word_idx     = {{(32-WORD_ADDR_BITS){1'b0}}, r_addr[AW-1:2]};
  assign Mem_Read       = r_state[0];
  assign Mem_Write      = r_state[1];
  assign Mem_Adress     = (Mem_Read || Mem_Write) ? w_word_idx : 32'd0;
  assign Mem_Write_Data = Mem_Write ? r_wdata : 32'd0;
  assign Load_Data      = r_load;
  assign Busy           = (r_state != S_IDLE);
  assign Done           = (r_state == S_DONE);
  assign Misaligned     = Done && r_mis;
  assign Out_Of_Range   = Done && r_oor;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomised bench for load_store_unit: a 32-word memory, a transaction-level
// model producing a per-cycle expected trace, and literal anchor checks.
module tb_load_store_unit;

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic        Start;
  logic [2:0]  MemOp;
  logic [31:0] Address;
  logic [31:0] Store_Data;
  logic [31:0] Mem_Read_Data;
  logic [31:0] Mem_Adress;
  logic [31:0] Mem_Write_Data;
  logic        Mem_Write;
  logic        Mem_Read;
  logic [31:0] Load_Data;
  logic        Busy;
  logic        Done;
  logic        Misaligned;
  logic        Out_Of_Range;

  load_store_unit #(.WORD_ADDR_BITS(5)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .MemOp(MemOp), .Address(Address),
    .Store_Data(Store_Data), .Mem_Read_Data(Mem_Read_Data), .Mem_Adress(Mem_Adress),
    .Mem_Write_Data(Mem_Write_Data), .Mem_Write(Mem_Write), .Mem_Read(Mem_Read),
    .Load_Data(Load_Data), .Busy(Busy), .Done(Done), .Misaligned(Misaligned),
    .Out_Of_Range(Out_Of_Range)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        busy, done, rd, wr, mis, oor;
    logic [31:0] addr, wdata, load;
  } exp_t;

  exp_t        exp_q[$];
  int          errors = 0;
  int          checks = 0;
  logic        chk_en = 1'b0;
  logic        done_mis = 1'b0;
  logic        done_oor = 1'b0;
  logic [31:0] m_load = 32'd0;
  logic [31:0] mem     [0:31];
  logic [31:0] ref_mem [0:31];
  int          wr_count = 0;
  logic [31:0] last_wr_addr = 32'd0;
  logic [31:0] last_wr_data = 32'd0;

  assign Mem_Read_Data = mem[Mem_Adress[4:0]];

  function automatic logic [31:0] init_word(input int i);
    if (i == 3) return 32'h8899AABB;
    return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A0F0F;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Data memory: combinational read, write on the rising edge.
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = init_word(i);
    forever begin
      @(posedge Clk);
      if (Mem_Write) begin
        mem[Mem_Adress[4:0]] <= Mem_Write_Data;
        wr_count     <= wr_count + 1;
        last_wr_addr <= Mem_Adress;
        last_wr_data <= Mem_Write_Data;
      end
    end
  end

  function automatic logic m_mis(input logic [2:0] op, input logic [31:0] a);
    if (op == 3'd1 || op == 3'd4 || op == 3'd6) return (a % 2) != 0;
    if (op == 3'd2 || op == 3'd7) return (a % 4) != 0;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_load_val(input logic [2:0] op, input logic [31:0] w,
                                             input logic [31:0] a);
    logic [31:0] lane, b, h;
    lane = a % 4;
    b = (w >> (lane * 8)) & 32'hFF;
    h = (w >> ((lane / 2) * 16)) & 32'hFFFF;
    case (op)
      3'd0:    return (b >= 128) ? b - 32'd256 : b;
      3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
      3'd2:    return w;
      3'd3:    return b;
      default: return h;
    endcase
  endfunction

  function automatic logic [31:0] m_store_val(input logic [2:0] op, input logic [31:0] w,
                                              input logic [31:0] a, input logic [31:0] sd);
    logic [31:0] lane, mask;
    lane = a % 4;
    if (op == 3'd5) begin
      mask = 32'hFF << (lane * 8);
      return (w & ~mask) | ((sd & 32'hFF) << (lane * 8));
    end
    if (op == 3'd6) begin
      mask = 32'hFFFF << ((lane / 2) * 16);
      return (w & ~mask) | ((sd & 32'hFFFF) << ((lane / 2) * 16));
    end
    return sd;
  endfunction

  // Per-cycle comparison against the expected trace (idle values when the trace is empty).
  initial begin
    exp_t        e;
    logic [31:0] cur_load;
    cur_load = 32'd0;
    forever begin
      @(negedge Clk);
      if (!Reset_n) begin
        cur_load = 32'd0;
      end else if (chk_en) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
        end else begin
          e.busy = 1'b0; e.done = 1'b0; e.rd = 1'b0; e.wr = 1'b0;
          e.mis = 1'b0; e.oor = 1'b0; e.addr = 32'd0; e.wdata = 32'd0;
          e.load = cur_load;
        end
        cur_load = e.load;
        chk("Busy", 32'(Busy), 32'(e.busy));
        chk("Done", 32'(Done), 32'(e.done));
        chk("Mem_Read", 32'(Mem_Read), 32'(e.rd));
        chk("Mem_Write", 32'(Mem_Write), 32'(e.wr));
        chk("Misaligned", 32'(Misaligned), 32'(e.mis));
        chk("Out_Of_Range", 32'(Out_Of_Range), 32'(e.oor));
        chk("Mem_Adress", Mem_Adress, e.addr);
        chk("Mem_Write_Data", Mem_Write_Data, e.wdata);
        chk("Load_Data", Load_Data, e.load);
        if (Done) begin
          done_mis = Misaligned;
          done_oor = Out_Of_Range;
        end
      end
    end
  end

  // Called just after a rising edge with the unit idle; returns with it idle again.
  task automatic do_op(input logic [2:0] op, input logic [31:0] addr,
                       input logic [31:0] sd, input bit hold);
    logic        mis, oor, fault, isld, rmw;
    logic [31:0] idx, neww, newload;
    int          n;
    exp_t        e;
    MemOp = op; Address = addr; Store_Data = sd; Start = 1'b1;
    mis   = m_mis(op, addr);
    oor   = addr >= 32'd128;
    fault = mis || oor;
    isld  = op <= 3'd4;
    rmw   = (op == 3'd5) || (op == 3'd6);
    idx   = (addr / 4) % 32;
    newload = m_load;
    neww    = 32'd0;
    if (!fault) begin
      if (isld) newload = m_load_val(op, ref_mem[idx], addr);
      else      neww    = m_store_val(op, ref_mem[idx], addr, sd);
    end
    n = fault ? 1 : ((isld || op == 3'd7) ? 2 : 3);
    @(posedge Clk);
    #1;
    for (int k = 1; k <= n; k++) begin
      e.busy  = 1'b1;
      e.done  = (k == n);
      e.rd    = !e.done && (isld || rmw) && (k == 1);
      e.wr    = !e.done && ((op == 3'd7 && k == 1) || (rmw && k == 2));
      e.addr  = (e.rd || e.wr) ? idx : 32'd0;
      e.wdata = e.wr ? neww : 32'd0;
      e.mis   = e.done && mis;
      e.oor   = e.done && oor;
      e.load  = e.done ? newload : m_load;
      exp_q.push_back(e);
    end
    if (!fault && !isld) ref_mem[idx] = neww;
    m_load = newload;
    #1;
    MemOp = 3'($urandom); Address = $urandom; Store_Data = $urandom;
    if (!hold) Start = 1'b0;
    repeat (n) @(posedge Clk);
    #2;
  endtask

  initial begin
    int          w0;
    logic [31:0] a;
    bit          hold;
    for (int i = 0; i < 32; i++) ref_mem[i] = init_word(i);
    Reset_n = 1'b0; Start = 1'b0; MemOp = 3'd0; Address = 32'd0; Store_Data = 32'd0;
    #1;
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_done", 32'(Done), 32'd0);
    chk("rst_rd", 32'(Mem_Read), 32'd0);
    chk("rst_wr", 32'(Mem_Write), 32'd0);
    chk("rst_addr", Mem_Adress, 32'd0);
    chk("rst_wdata", Mem_Write_Data, 32'd0);
    chk("rst_load", Load_Data, 32'd0);
    chk("rst_flags", {30'd0, Misaligned, Out_Of_Range}, 32'd0);
    Start = 1'b1; MemOp = 3'd2;
    #12;
    chk("rst_start_busy", 32'(Busy), 32'd0);
    Start = 1'b0;
    @(posedge Clk);
    #2;
    Reset_n = 1'b1;
    chk_en  = 1'b1;

    do_op(3'd0, 32'h0000000D, $urandom, 1'b0);
    chk("lit_lb", Load_Data, 32'hFFFFFFAA);
    do_op(3'd3, 32'h0000000D, $urandom, 1'b0);
    chk("lit_lbu", Load_Data, 32'h000000AA);
    w0 = wr_count;
    do_op(3'd6, 32'h0000000E, 32'h12345678, 1'b0);
    chk("lit_sh_writes", 32'(wr_count - w0), 32'd1);
    chk("lit_sh_addr", last_wr_addr, 32'd3);
    chk("lit_sh_data", last_wr_data, 32'h5678AABB);
    chk("lit_sh_mem", mem[3], 32'h5678AABB);
    w0 = wr_count;
    do_op(3'd2, 32'h00000006, $urandom, 1'b0);
    chk("lit_lw6_mis", 32'(done_mis), 32'd1);
    chk("lit_lw6_oor", 32'(done_oor), 32'd0);
    do_op(3'd2, 32'h00000080, $urandom, 1'b0);
    chk("lit_lw80_oor", 32'(done_oor), 32'd1);
    chk("lit_lw80_mis", 32'(done_mis), 32'd0);
    chk("lit_fault_writes", 32'(wr_count - w0), 32'd0);

    w0 = wr_count;
    for (int i = 0; i < 3; i++) do_op(3'd7, 32'(4 * (8 + i)), $urandom, 1'b1);
    Start = 1'b0;
    chk("held_sw_writes", 32'(wr_count - w0), 32'd3);

    for (int t = 0; t < 300; t++) begin
      a = (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) a = a | (32'd1 << $urandom_range(7, 31));
      hold = ($urandom_range(0, 3) == 0);
      do_op(3'($urandom_range(0, 7)), a, $urandom, hold);
      if (!hold) repeat ($urandom_range(0, 2)) begin @(posedge Clk); #2; end
    end
    Start = 1'b0;
    for (int i = 0; i < 32; i++) chk("mem_final", mem[i], ref_mem[i]);

    // Reset while an SB sits in its read cycle.
    MemOp = 3'd5; Address = 32'h00000015; Store_Data = $urandom; Start = 1'b1;
    @(posedge Clk);
    #1;
    Start = 1'b0;
    w0 = wr_count;
    #2;
    Reset_n = 1'b0;
    exp_q.delete();
    #1;
    chk("abort_rd", 32'(Mem_Read), 32'd0);
    chk("abort_wr", 32'(Mem_Write), 32'd0);
    chk("abort_busy", 32'(Busy), 32'd0);
    chk("abort_addr", Mem_Adress, 32'd0);
    chk("abort_load", Load_Data, 32'd0);
    repeat (3) @(posedge Clk);
    #1;
    chk("abort_writes", 32'(wr_count - w0), 32'd0);
    chk("abort_mem", mem[5], ref_mem[5]);
    chk("abort_outs", {Mem_Write_Data | Mem_Adress}, 32'd0);
    m_load = 32'd0;
    #1;
    Reset_n = 1'b1;
    do_op(3'd2, 32'h00000014, $urandom, 1'b0);
    chk("post_reset_lw", Load_Data, ref_mem[5]);
    do_op(3'd5, 32'h00000017, 32'h000000C3, 1'b0);
    do_op(3'd4, 32'h00000016, $urandom, 1'b0);
    repeat (2) @(posedge Clk);
    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter WORD_ADDR_BITS, default 5, SHALL set the word-index width (32-word data memory).
REQ-002 Clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-003 Reset_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 Start  input  1  SHALL request one memory operation.
REQ-005 MemOp  input  3  SHALL select the operation: 000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU, 101 SB, 110 SH, 111 SW.
REQ-006 Address  input  32  SHALL be the byte address from the ALU.
REQ-007 Store_Data  input  32  SHALL be the register value to store; the low byte or halfword is used for SB/SH.
REQ-008 Mem_Read_Data  input  32  SHALL be the word returned combinationally by the data memory.
REQ-009 Mem_Adress  output  32  SHALL be the word index to the data memory, zero-extended.
REQ-010 Mem_Write_Data  output  32  SHALL be the full word to write.
REQ-011 Mem_Write, Mem_Read  output  1 each  SHALL be the data-memory strobes.
REQ-012 Load_Data  output  32  SHALL be the extended load result.
REQ-013 Busy  output  1  SHALL be 1 whenever the FSM is not in IDLE.
REQ-014 Done  output  1  SHALL be a one-cycle completion pulse.
REQ-015 Misaligned, Out_Of_Range  output  1 each  SHALL be fault flags, valid only while Done=1.

Function
REQ-016 The FSM SHALL have the states IDLE, RD, WR, DONE.
REQ-017 Start SHALL be accepted only in IDLE; Start in any other state SHALL be ignored, with no queuing.
REQ-018 On acceptance, MemOp, Address and Store_Data SHALL be registered; later changes to these inputs SHALL have no effect on the operation.
REQ-019 Alignment fault: halfword ops with Address[0]=1, and word ops with Address[1:0]!=0.
REQ-020 Range fault: Address[31:WORD_ADDR_BITS+2] not equal to 0.
REQ-021 Fault path: IDLE -> DONE with the matching flag(s) set; no Mem_Read or Mem_Write in any cycle; Load_Data unchanged.
REQ-022 Load path (LB, LH, LW, LBU, LHU): IDLE -> RD -> DONE; Done asserts 2 cycles after the acceptance edge.
REQ-023 SW path: IDLE -> WR -> DONE; Mem_Write_Data = Store_Data.
REQ-024 SB/SH path: IDLE -> RD -> WR -> DONE (read-modify-write); Done asserts 3 cycles after acceptance.
REQ-025 In RD, Mem_Read=1 and Mem_Read_Data SHALL be captured at the end of the cycle.
REQ-026 In WR, Mem_Write=1 for exactly one cycle.
REQ-027 Mem_Write and Mem_Read SHALL be decoded from the registered state only and SHALL be glitch-free; both are 0 in IDLE and DONE.
REQ-028 Mem_Adress SHALL equal Address[WORD_ADDR_BITS+1:2] of the registered address in RD and WR, and 0 otherwise.
REQ-029 Byte lanes SHALL be little-endian: lane = Address[1:0]; halfword lane = Address[1].
REQ-030 SB/SH merge: only the addressed lane(s) SHALL be replaced in the captured word; all other bits are preserved.
REQ-031 Loads: LB/LH sign-extend and LBU/LHU zero-extend the selected lane; Load_Data updates on entry to DONE and holds until the next successful load.
REQ-032 DONE SHALL last one cycle and then return to IDLE; Done=1 only in DONE.
REQ-033 Fault flags SHALL be 0 whenever Done=0.

Reset
REQ-034 Reset_n=0 SHALL immediately force IDLE and drive all outputs to 0, including Load_Data and Mem_Adress.
REQ-035 Reset asserted during RD or WR SHALL abort the operation, with no Mem_Write in the cycle after the reset assertion.
REQ-036 After Reset_n rises, the first Start SHALL be accepted on the first rising edge at which Start=1.

Verification
REQ-037 Memory word 3 = 0x8899AABB; LB at 0x0000000D -> Done at +2 cycles, Load_Data = 0xFFFFFFAA; LBU at the same address -> 0x000000AA.
REQ-038 SH of Store_Data = 0x12345678 at 0x0000000E over word 3 = 0x8899AABB -> one Mem_Write with Mem_Adress=3 and Mem_Write_Data = 0x5678AABB; Done at +3.
REQ-039 LW at 0x00000006 -> Done at +1 with Misaligned=1 and no strobes; LW at 0x00000080 -> Out_Of_Range=1.
REQ-040 Start held high continuously through an SW sequence -> exactly one write per pass through IDLE; Start during Busy is ignored.
REQ-041 Reset_n pulled low in the RD state of an SB -> Mem_Write never asserts, memory is unchanged, and all outputs are 0.
